counter_datacheck: RTL and testbench
====================================

COUNTER_DATACHECK -- requirements
Module: counter_datacheck

Interface
REQ-001 Parameter LOCK_COUNT, 16: consecutive matching words needed to declare lock.
REQ-002 Parameter UNLOCK_ERRS, 4: consecutive mismatching words, while locked, that force loss of lock.
REQ-003 Parameter CNT_W, 32: width of word_count and error_count.
REQ-004 One clock; reset is asynchronous and active-high; ports named clk and rst.
REQ-005 clk  in  1  fabric clock, 160 MHz domain of the RX FIFO read side.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 data_in  in  8  deserialized word from the RX data lane.
REQ-008 valid_in  in  1  data_in is valid this cycle.
REQ-009 clr_counts  in  1  synchronous clear of all statistics counters.
REQ-010 aligned_data  out  8  last sampled word after rotation by slip.
REQ-011 slip  out  3  current rotate-right amount applied to data_in.
REQ-012 locked  out  1  checker is in LOCKED state.
REQ-013 err_pulse  out  1  one-cycle pulse per mismatch counted while locked.
REQ-014 word_count  out  CNT_W  valid words compared while locked, saturating.
REQ-015 error_count  out  CNT_W  mismatches while locked, saturating.
REQ-016 lock_loss_count  out  8  LOCKED-to-HUNT transitions, saturating.

Function
REQ-017 Stage 1: at each edge with valid_in=1, register rot = data_in rotated right by slip, plus a valid flag; aligned_data = that register.
REQ-018 Stage 2: a valid stage-1 word is compared with expected = ref + 1 mod 256; all status outputs update at the edge after the word is sampled (1-edge latency).
REQ-019 ref is invalid after reset, after a slip change and on entering HUNT; the first usable word then only loads ref, with no compare.
REQ-020 On a match, ref takes the received word; cycles with valid_in=0 do not change state, counters or ref.
REQ-021 FSM states: HUNT (reset state) and LOCKED.
REQ-022 HUNT, match: good_run increments; on reaching LOCK_COUNT, go to LOCKED, locked=1, err_run=0.
REQ-023 HUNT, mismatch: slip increments mod 8 (7 wraps to 0), good_run=0, ref invalid, next valid stage-1 word discarded because it was rotated with the old slip.
REQ-024 LOCKED, match: word_count+1, err_run=0.
REQ-025 LOCKED, mismatch: word_count+1, error_count+1, err_pulse=1, err_run+1; ref advances to expected, not to the received word, so one corrupted word gives exactly one error.
REQ-026 LOCKED, err_run reaching UNLOCK_ERRS: go to HUNT, locked=0, lock_loss_count+1, good_run=0, ref invalid, slip unchanged.
REQ-027 All counters saturate at all-ones and never wrap.
REQ-028 clr_counts=1 zeroes word_count, error_count and lock_loss_count at the next edge; clear wins over a simultaneous increment; FSM, slip and ref are unaffected.
REQ-029 No counting and no err_pulse in HUNT.

Reset
REQ-030 rst=1 immediately forces: state HUNT, slip=0, locked=0, err_pulse=0, aligned_data=0, all counters=0, good_run=0, err_run=0, ref invalid, stage-1 valid=0.
REQ-031 Reset asserted mid-lock or mid-hunt abandons all progress; after release, lock acquisition restarts from slip 0.

Structure
REQ-032 Shared package holds the state enum (HUNT, LOCKED) and default constants for LOCK_COUNT, UNLOCK_ERRS and CNT_W.
REQ-033 One sub-module, sat_counter (parameterised width, inc, clr, clear-priority, saturating), instantiated for the three statistics counters.

Verification
REQ-034 Reset, then data_in=0x00..0x27 with valid_in=1 -> locked=1 one edge after word 0x10 is sampled, slip=0, error_count=0.
REQ-035 data_in = counter rotated left by 3 -> slip steps 0,1,2,3 then stays at 3, locked=1, aligned_data follows the plain counter sequence.
REQ-036 Locked; replace 0x20 with 0x55 -> one err_pulse, error_count=1, locked stays 1, following 0x21 matches.
REQ-037 Locked; four consecutive corrupted words -> locked=0 after the fourth, lock_loss_count=1, error_count=4, slip unchanged.
REQ-038 valid_in toggling every other cycle -> lock after 16 valid matches; word_count counts only valid words.
REQ-039 Locked with error_count=5, assert rst for 1 ns mid-cycle -> all outputs zero at once; separately, clr_counts during a mismatch -> counters 0, err_pulse still 1.

Source files
------------

// File: rtl/counter_datacheck_pkg.sv
// ---------------------------------------------------------------------------
// counter_datacheck_pkg
//
// Shared definitions for the counter-pattern data checker:
//   - chk_state_e      : checker FSM states (HUNT, LOCKED)
//   - DEF_LOCK_COUNT   : default consecutive matches needed to declare lock
//   - DEF_UNLOCK_ERRS  : default consecutive mismatches that drop lock
//   - DEF_CNT_W        : default width of the word/error statistics counters
//   - rotRight()       : 8-bit rotate-right used to realign the RX lane
// ---------------------------------------------------------------------------
package counter_datacheck_pkg;

   localparam int DEF_LOCK_COUNT  = 16;
   localparam int DEF_UNLOCK_ERRS = 4;
   localparam int DEF_CNT_W       = 32;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } chk_state_e;

   // Rotate an 8-bit word right by 0..7 positions. When the amount is zero
   // the left shift by 8 falls off the 8-bit result, leaving d unchanged.
   function automatic logic [7:0] rotRight(input logic [7:0] d, input logic [2:0] s);
      return (d >> s) | (d << (4'd8 - {1'b0, s}));
   endfunction

endpackage

// File: rtl/counter_datacheck_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//
// Saturating up-counter with a synchronous clear that has priority over the
// increment. Once the count reaches all-ones it holds there until cleared.
//
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-high reset (count -> 0)
//   clr_i    in   synchronous clear, wins over inc_i
//   inc_i    in   add one this cycle (ignored when saturated)
//   count_o  out  current count, WIDTH bits
// ---------------------------------------------------------------------------
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Next count: clear first, then a guarded increment so the value sticks
   // at all-ones instead of wrapping back to zero.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != '1)) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   // Count register with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/counter_datacheck.sv
// ---------------------------------------------------------------------------
// counter_datacheck
//
// Checks that an 8-bit RX lane carries an incrementing counter pattern. The
// lane may arrive bit-rotated; while hunting, every mismatch bumps the
// rotate-right amount (slip) until the counter lines up and LOCK_COUNT
// consecutive matches are seen. While locked, each mismatch is counted and
// pulsed once; UNLOCK_ERRS consecutive mismatches drop back to hunting.
//
// Ports:
//   clk              in   fabric clock (RX FIFO read side)
//   rst              in   asynchronous active-high reset
//   data_in[7:0]     in   deserialized word from the RX data lane
//   valid_in         in   data_in is valid this cycle
//   clr_counts       in   synchronous clear of the statistics counters
//   aligned_data[7:0]out  last sampled word after rotation by slip
//   slip[2:0]        out  rotate-right amount currently applied to data_in
//   locked           out  checker is in LOCKED
//   err_pulse        out  one-cycle pulse per mismatch while locked
//   word_count       out  words compared while locked (saturating)
//   error_count      out  mismatches while locked (saturating)
//   lock_loss_count  out  LOCKED-to-HUNT transitions (saturating)
// ---------------------------------------------------------------------------
module counter_datacheck
   import counter_datacheck_pkg::*;
#(
   parameter int LOCK_COUNT  = DEF_LOCK_COUNT,
   parameter int UNLOCK_ERRS = DEF_UNLOCK_ERRS,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       data_in,
   input  logic             valid_in,
   input  logic             clr_counts,
   output logic [7:0]       aligned_data,
   output logic [2:0]       slip,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] word_count,
   output logic [CNT_W-1:0] error_count,
   output logic [7:0]       lock_loss_count
);

   localparam int GW = $clog2(LOCK_COUNT + 1);
   localparam int EW = $clog2(UNLOCK_ERRS + 1);

   chk_state_e      state_q;
   logic [2:0]      slip_q;
   logic [7:0]      rot_q;
   logic            s1Valid_q;
   logic [7:0]      ref_q;
   logic            refValid_q;
   logic            discard_q;
   logic [GW-1:0]   goodRun_q;
   logic [EW-1:0]   errRun_q;
   logic            errPulse_q;

   logic [7:0]      rotData;
   logic [7:0]      expected;
   logic            compareEn;
   logic            isMatch;
   logic            wordInc;
   logic            errInc;
   logic            lossInc;
   logic            lockReached;

   assign rotData  = rotRight(data_in, slip_q);
   assign expected = ref_q + 8'd1;

   // A stage-1 word is only compared when it was not rotated with a stale
   // slip and a reference word exists. Counter increments are derived here
   // so the three statistics counters update on the same edge as the FSM.
   always_comb begin
      compareEn   = s1Valid_q && !discard_q && refValid_q;
      isMatch     = (rot_q == expected);
      wordInc     = compareEn && (state_q == LOCKED);
      errInc      = wordInc && !isMatch;
      lossInc     = errInc && (errRun_q == EW'(UNLOCK_ERRS - 1));
      lockReached = (goodRun_q == GW'(LOCK_COUNT - 1));
   end

   // Stage-1 capture plus the HUNT/LOCKED checker. Stage 2 works on the word
   // captured on the previous edge, so slip changes made here only affect
   // words captured from the next edge onward; the word captured on this
   // same edge used the old slip and is marked for discard. While locked a
   // mismatch advances the reference to the expected value rather than the
   // received word, so one corrupted word produces exactly one error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= HUNT;
         slip_q     <= 3'd0;
         rot_q      <= 8'd0;
         s1Valid_q  <= 1'b0;
         ref_q      <= 8'd0;
         refValid_q <= 1'b0;
         discard_q  <= 1'b0;
         goodRun_q  <= '0;
         errRun_q   <= '0;
         errPulse_q <= 1'b0;
      end else begin
         errPulse_q <= 1'b0;
         s1Valid_q  <= valid_in;
         if (valid_in) begin
            rot_q <= rotData;
         end

         if (s1Valid_q) begin
            if (discard_q) begin
               discard_q <= 1'b0;
            end else if (!refValid_q) begin
               ref_q      <= rot_q;
               refValid_q <= 1'b1;
            end else begin
               case (state_q)
                  HUNT: begin
                     if (isMatch) begin
                        ref_q <= rot_q;
                        if (lockReached) begin
                           state_q   <= LOCKED;
                           goodRun_q <= '0;
                           errRun_q  <= '0;
                        end else begin
                           goodRun_q <= goodRun_q + GW'(1);
                        end
                     end else begin
                        slip_q     <= slip_q + 3'd1;
                        goodRun_q  <= '0;
                        refValid_q <= 1'b0;
                        discard_q  <= 1'b1;
                     end
                  end
                  LOCKED: begin
                     if (isMatch) begin
                        ref_q    <= rot_q;
                        errRun_q <= '0;
                     end else begin
                        ref_q      <= expected;
                        errPulse_q <= 1'b1;
                        if (lossInc) begin
                           state_q    <= HUNT;
                           goodRun_q  <= '0;
                           errRun_q   <= '0;
                           refValid_q <= 1'b0;
                        end else begin
                           errRun_q <= errRun_q + EW'(1);
                        end
                     end
                  end
                  default: begin
                     state_q <= HUNT;
                  end
               endcase
            end
         end
      end
   end

   sat_counter #(.WIDTH(CNT_W)) uWordCount (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (clr_counts),
      .inc_i   (wordInc),
      .count_o (word_count)
   );

   sat_counter #(.WIDTH(CNT_W)) uErrorCount (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (clr_counts),
      .inc_i   (errInc),
      .count_o (error_count)
   );

   sat_counter #(.WIDTH(8)) uLossCount (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (clr_counts),
      .inc_i   (lossInc),
      .count_o (lock_loss_count)
   );

   assign aligned_data = rot_q;
   assign slip         = slip_q;
   assign locked       = (state_q == LOCKED);
   assign err_pulse    = errPulse_q;

endmodule

// File: tb/tb_counter_datacheck.sv
// ---------------------------------------------------------------------------
// tb_counter_datacheck
//
// Drives counter-pattern traffic (plain, rotated, corrupted, gapped and
// random) into counter_datacheck. Every edge the driver advances a
// behavioural reference model and queues the expected outputs; a separate
// monitor pops one entry per falling edge and compares it with the DUT.
// ---------------------------------------------------------------------------
`timescale 1ns/100ps
module tb_counter_datacheck;

   localparam int LC = 16;
   localparam int UE = 4;
   localparam int CW = 32;
   localparam longint MAXC = 64'hFFFF_FFFF;

   logic          clk;
   logic          rst;
   logic [7:0]    data_in;
   logic          valid_in;
   logic          clr_counts;
   logic [7:0]    aligned_data;
   logic [2:0]    slip;
   logic          locked;
   logic          err_pulse;
   logic [CW-1:0] word_count;
   logic [CW-1:0] error_count;
   logic [7:0]    lock_loss_count;

   typedef struct {
      logic [7:0]  aligned;
      logic [2:0]  slip;
      logic        locked;
      logic        errPulse;
      logic [31:0] words;
      logic [31:0] errs;
      logic [7:0]  loss;
   } snap_t;

   snap_t sbQ[$];

   int nChecks = 0;
   int nFails  = 0;

   // Reference model state, kept in plain integers
   logic [7:0] mRef, mS1Word, mAligned;
   bit         mRefV, mS1V, mDiscard, mLocked, mErrPulse;
   int         mGood, mErrRun, mSlip, mLoss;
   longint     mWords, mErrs;

   counter_datacheck #(.LOCK_COUNT(LC), .UNLOCK_ERRS(UE), .CNT_W(CW)) dut (
      .clk             (clk),
      .rst             (rst),
      .data_in         (data_in),
      .valid_in        (valid_in),
      .clr_counts      (clr_counts),
      .aligned_data    (aligned_data),
      .slip            (slip),
      .locked          (locked),
      .err_pulse       (err_pulse),
      .word_count      (word_count),
      .error_count     (error_count),
      .lock_loss_count (lock_loss_count)
   );

   // 100 MHz-ish bench clock; absolute frequency is irrelevant to the checker
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Rotation helpers built from a doubled word
   function automatic logic [7:0] rotr(input logic [7:0] d, input int s);
      logic [15:0] x;
      x = {d, d} >> s;
      return x[7:0];
   endfunction

   function automatic logic [7:0] rol(input logic [7:0] d, input int s);
      logic [15:0] x;
      x = {d, d} << s;
      return x[15:8];
   endfunction

   // One comparison: counts it and reports a FAIL line on mismatch
   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Compare every DUT output against one expected snapshot
   task automatic checkOutput(input snap_t e, input string tag);
      cmp({tag, ".aligned_data"},    32'(aligned_data),    32'(e.aligned));
      cmp({tag, ".slip"},            32'(slip),            32'(e.slip));
      cmp({tag, ".locked"},          32'(locked),          32'(e.locked));
      cmp({tag, ".err_pulse"},       32'(err_pulse),       32'(e.errPulse));
      cmp({tag, ".word_count"},      32'(word_count),      e.words);
      cmp({tag, ".error_count"},     32'(error_count),     e.errs);
      cmp({tag, ".lock_loss_count"}, 32'(lock_loss_count), 32'(e.loss));
   endtask

   function automatic snap_t snap();
      snap_t s;
      s.aligned  = mAligned;
      s.slip     = 3'(mSlip);
      s.locked   = mLocked;
      s.errPulse = mErrPulse;
      s.words    = 32'(mWords);
      s.errs     = 32'(mErrs);
      s.loss     = 8'(mLoss);
      return s;
   endfunction

   task automatic modelReset();
      mRef = 0; mS1Word = 0; mAligned = 0;
      mRefV = 0; mS1V = 0; mDiscard = 0; mLocked = 0; mErrPulse = 0;
      mGood = 0; mErrRun = 0; mSlip = 0; mLoss = 0;
      mWords = 0; mErrs = 0;
   endtask

   // Advance the model by one clock edge with the given inputs
   task automatic modelEdge(input logic [7:0] d, input bit v, input bit c);
      logic [7:0] w, exp;
      int oldSlip;
      oldSlip   = mSlip;
      mErrPulse = 0;
      if (mS1V) begin
         w = mS1Word;
         if (mDiscard) begin
            mDiscard = 0;
         end else if (!mRefV) begin
            mRef  = w;
            mRefV = 1;
         end else begin
            exp = 8'(mRef + 1);
            if (!mLocked) begin
               if (w == exp) begin
                  mRef = w;
                  mGood++;
                  if (mGood == LC) begin
                     mLocked = 1; mErrRun = 0; mGood = 0;
                  end
               end else begin
                  mSlip = (mSlip + 1) % 8;
                  mGood = 0; mRefV = 0; mDiscard = 1;
               end
            end else begin
               if (mWords < MAXC) mWords++;
               if (w == exp) begin
                  mRef = w; mErrRun = 0;
               end else begin
                  if (mErrs < MAXC) mErrs++;
                  mErrPulse = 1;
                  mErrRun++;
                  mRef = exp;
                  if (mErrRun == UE) begin
                     mLocked = 0;
                     if (mLoss < 255) mLoss++;
                     mGood = 0; mRefV = 0; mErrRun = 0;
                  end
               end
            end
         end
      end
      if (c) begin
         mWords = 0; mErrs = 0; mLoss = 0;
      end
      if (v) begin
         mS1Word  = rotr(d, oldSlip);
         mS1V     = 1;
         mAligned = mS1Word;
      end else begin
         mS1V = 0;
      end
   endtask

   // Drive one cycle of inputs, step the model at the edge and queue the
   // outputs the DUT must show after that edge
   task automatic applyStimulus(input logic [7:0] d, input bit v, input bit c);
      data_in    = d;
      valid_in   = v;
      clr_counts = c;
      @(posedge clk);
      modelEdge(d, v, c);
      sbQ.push_back(snap());
      #1;
   endtask

   // 1 ns reset pulse away from the clock edge; outputs must clear at once
   task automatic resetPulse(input string tag);
      @(negedge clk);
      #1;
      sbQ.delete();
      rst = 1'b1;
      #0.5;
      modelReset();
      checkOutput(snap(), tag);
      #0.5;
      rst = 1'b0;
   endtask

   // Monitor: one expected entry per falling edge
   initial begin
      snap_t e;
      forever begin
         @(negedge clk);
         if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkOutput(e, "sb");
         end
      end
   end

   // Watchdog so a stuck run still reports
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int c;
      int burst;
      int rotL;
      bit v;
      bit cl;
      logic [7:0] d;

      rst        = 1'b1;
      data_in    = 8'd0;
      valid_in   = 1'b0;
      clr_counts = 1'b0;

      // Plain counter: lock one edge after 0x10 is sampled
      resetPulse("reset");
      for (int i = 0; i <= 16; i++) applyStimulus(8'(i), 1'b1, 1'b0);
      cmp("lockEdge.before", 32'(locked), 32'd0);
      applyStimulus(8'h11, 1'b1, 1'b0);
      cmp("lockEdge.after", 32'(locked), 32'd1);
      for (int i = 8'h12; i <= 8'h27; i++) applyStimulus(8'(i), 1'b1, 1'b0);
      applyStimulus(8'h00, 1'b0, 1'b0);
      cmp("plain.slip", 32'(slip), 32'd0);
      cmp("plain.error_count", error_count, 32'd0);

      // Lane rotated left by 3: hunting settles on slip 3
      resetPulse("reset.rot");
      for (int i = 0; i < 80; i++) applyStimulus(rol(8'(i), 3), 1'b1, 1'b0);
      cmp("rot.slip", 32'(slip), 32'd3);
      cmp("rot.locked", 32'(locked), 32'd1);
      cmp("rot.aligned", 32'(aligned_data), 32'd79);

      // Single corrupted word while locked
      resetPulse("reset.single");
      for (int i = 0; i < 8'h20; i++) applyStimulus(8'(i), 1'b1, 1'b0);
      applyStimulus(8'h55, 1'b1, 1'b0);
      for (int i = 8'h21; i <= 8'h27; i++) applyStimulus(8'(i), 1'b1, 1'b0);
      applyStimulus(8'h00, 1'b0, 1'b0);
      cmp("single.error_count", error_count, 32'd1);
      cmp("single.locked", 32'(locked), 32'd1);
      cmp("single.word_count", word_count, 32'd23);

      // Four consecutive corrupted words drop lock
      resetPulse("reset.loss");
      for (int i = 0; i < 8'h20; i++) applyStimulus(8'(i), 1'b1, 1'b0);
      for (int i = 8'h20; i < 8'h24; i++) applyStimulus(8'(i) ^ 8'hFF, 1'b1, 1'b0);
      applyStimulus(8'h24, 1'b1, 1'b0);
      cmp("loss.locked", 32'(locked), 32'd0);
      cmp("loss.lock_loss_count", 32'(lock_loss_count), 32'd1);
      cmp("loss.error_count", error_count, 32'd4);
      cmp("loss.slip", 32'(slip), 32'd0);
      for (int i = 8'h25; i < 8'h2A; i++) applyStimulus(8'(i), 1'b1, 1'b0);

      // valid_in toggling every other cycle
      resetPulse("reset.gap");
      c = 0;
      for (int n = 0; n < 60; n++) begin
         if ((n % 2) == 0) begin
            applyStimulus(8'(c), 1'b1, 1'b0);
            c++;
         end else begin
            applyStimulus(8'($urandom), 1'b0, 1'b0);
         end
      end
      cmp("gap.locked", 32'(locked), 32'd1);
      cmp("gap.word_count", word_count, 32'd13);

      // Five isolated errors, then a mid-cycle reset
      resetPulse("reset.five");
      for (int i = 0; i < 8'h20; i++) applyStimulus(8'(i), 1'b1, 1'b0);
      for (int i = 8'h20; i < 8'h2A; i++)
         applyStimulus(((i % 2) == 0) ? (8'(i) ^ 8'hFF) : 8'(i), 1'b1, 1'b0);
      applyStimulus(8'h2A, 1'b1, 1'b0);
      cmp("five.error_count", error_count, 32'd5);
      resetPulse("midReset");

      // Clear coinciding with a mismatch
      for (int i = 0; i < 8'h20; i++) applyStimulus(8'(i), 1'b1, 1'b0);
      applyStimulus(8'h20 ^ 8'hFF, 1'b1, 1'b0);
      applyStimulus(8'h21, 1'b1, 1'b1);
      cmp("clr.err_pulse", 32'(err_pulse), 32'd1);
      cmp("clr.error_count", error_count, 32'd0);
      cmp("clr.word_count", word_count, 32'd0);
      for (int i = 8'h22; i < 8'h28; i++) applyStimulus(8'(i), 1'b1, 1'b0);

      // Randomized traffic: gaps, corruption, bursts, clears, lane rotation
      resetPulse("reset.rand");
      c = 0; burst = 0; rotL = 0;
      for (int n = 0; n < 3000; n++) begin
         if ((n % 600) == 0) rotL = $urandom_range(0, 7);
         if ($urandom_range(0, 299) == 0) burst = 4;
         v  = ($urandom_range(0, 9) < 7);
         cl = ($urandom_range(0, 199) == 0);
         if (v) begin
            d = 8'(c);
            if (burst > 0 || $urandom_range(0, 49) == 0)
               d = d ^ 8'($urandom_range(1, 255));
            if (burst > 0) burst--;
            c++;
            applyStimulus(rol(d, rotL), 1'b1, cl);
         end else begin
            applyStimulus(8'($urandom), 1'b0, cl);
         end
      end

      // Lock/lose repeatedly until lock_loss_count saturates
      resetPulse("reset.sat");
      c = 0;
      for (int r = 0; r < 260; r++) begin
         for (int k = 0; k < 18; k++) begin
            applyStimulus(8'(c), 1'b1, 1'b0);
            c++;
         end
         for (int k = 0; k < 4; k++) begin
            applyStimulus(8'(c) ^ 8'hFF, 1'b1, 1'b0);
            c++;
         end
      end
      applyStimulus(8'(c), 1'b1, 1'b0);
      applyStimulus(8'h00, 1'b0, 1'b0);
      cmp("sat.lock_loss_count", 32'(lock_loss_count), 32'd255);
      cmp("sat.error_count", error_count, 32'd1040);

      @(negedge clk);
      #1;
      cmp("scoreboard.drained", 32'(sbQ.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
